mem_stage: RTL

- Memory-access stage of the 5-stage pipeline CPU. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs data-RAM loads and stores: word loads, lbu byte loads, word stores and byte stores.
- Registers everything the write-back stage needs into an internal MEM/WB register.
- Latches a sticky halt on syscall and keeps load/store event counters for the debug display.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_if.sv | 40 ++++
 rtl/mem_stage_data_ram.sv | 27 ++
 rtl/mem_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage and the instruction decoder:
// memory operation codes carried on mem_label.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LOAD = 2'b01,
        MEM_SW   = 2'b10,
        MEM_SB   = 2'b11
    } mem_op_e;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage.
// The slave side is the stage itself; the master side is its environment.
interface mem_stage_if #(
    parameter int CNT_W = 32
);
    // EX/MEM side
    logic [31:0]      PC;
    logic [31:0]      result;
    logic [31:0]      ram_write;
    logic [4:0]       Rw;
    logic             we;
    logic             syscall;
    logic             lbu;
    logic             jal;
    logic [1:0]       mem_label;

    // MEM/WB side and debug
    logic [31:0]      PC_out;
    logic [31:0]      result_out;
    logic [31:0]      load_data_out;
    logic [4:0]       Rw_out;
    logic             we_out;
    logic             jal_out;
    logic             mem_to_reg_out;
    logic             halt;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    modport master (
        output PC, result, ram_write, Rw, we, syscall, lbu, jal, mem_label,
        input  PC_out, result_out, load_data_out, Rw_out, we_out, jal_out,
               mem_to_reg_out, halt, load_cnt, store_cnt
    );

    modport slave (
        input  PC, result, ram_write, Rw, we, syscall, lbu, jal, mem_label,
        output PC_out, result_out, load_data_out, Rw_out, we_out, jal_out,
               mem_to_reg_out, halt, load_cnt, store_cnt
    );
endinterface

// File: rtl/mem_stage_data_ram.sv
// Word-organised data RAM: synchronous byte-enabled write, combinational read.
// Contents are never reset.
module data_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // Byte-lane write; lane 0 is bits 7:0.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Read returns the contents before any write at the coming edge.
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data RAM access, load formatting, MEM/WB register,
// sticky syscall halt and load/store event counters.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_if.slave      bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Zero-extended byte selected by the lane offset (little-endian).
    function automatic logic [31:0] lane_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
        return {24'b0, word[lane*8 +: 8]};
    endfunction

    logic [ADDR_W-1:0] w_word_idx;
    logic [1:0]        w_lane;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_store_en;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_load_data;

    logic [31:0]       r_pc_p1;
    logic [31:0]       r_result_p1;
    logic [31:0]       r_load_data_p1;
    logic [4:0]        r_rw_p1;
    logic              r_we_p1;
    logic              r_jal_p1;
    logic              r_mem_to_reg_p1;
    logic              r_halt;
    logic [CNT_W-1:0]  r_load_cnt;
    logic [CNT_W-1:0]  r_store_cnt;

    // Upper address bits are dropped so addresses wrap modulo the RAM depth.
    assign w_word_idx = bus.result[ADDR_W+1:2];
    assign w_lane     = bus.result[1:0];
    assign w_is_load  = (bus.mem_label == MEM_LOAD);
    assign w_is_store = (bus.mem_label == MEM_SW) || (bus.mem_label == MEM_SB);
    assign w_store_en = w_is_store && !r_halt && !rst;

    // Byte enables and write data for word vs. byte stores.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.ram_write;
        if (w_store_en) begin
            if (bus.mem_label == MEM_SB) begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.ram_write[7:0]}};
            end else begin
                w_be    = 4'b1111;
            end
        end
    end

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk     (clk),
        .i_addr  (w_word_idx),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Format load data; non-load cycles produce zero.
    always_comb begin
        w_load_data = 32'b0;
        if (w_is_load) begin
            w_load_data = bus.lbu ? lane_byte(w_rdata, w_lane) : w_rdata;
        end
    end

    // ---- MEM/WB boundary: keeps updating even while halted ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_p1         <= 32'b0;
            r_result_p1     <= 32'b0;
            r_load_data_p1  <= 32'b0;
            r_rw_p1         <= 5'b0;
            r_we_p1         <= 1'b0;
            r_jal_p1        <= 1'b0;
            r_mem_to_reg_p1 <= 1'b0;
        end else begin
            r_pc_p1         <= bus.PC;
            r_result_p1     <= bus.result;
            r_load_data_p1  <= w_load_data;
            r_rw_p1         <= bus.Rw;
            r_we_p1         <= bus.we;
            r_jal_p1        <= bus.jal;
            r_mem_to_reg_p1 <= w_is_load;
        end
    end

    // Sticky halt latch; a syscall cycle's own store still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (bus.syscall) begin
            r_halt <= 1'b1;
        end
    end

    // Load/store event counters, frozen while halted, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else if (!r_halt) begin
            if (w_is_load) begin
                r_load_cnt <= r_load_cnt + CNT_ONE;
            end
            if (w_is_store) begin
                r_store_cnt <= r_store_cnt + CNT_ONE;
            end
        end
    end

    assign bus.PC_out         = r_pc_p1;
    assign bus.result_out     = r_result_p1;
    assign bus.load_data_out  = r_load_data_p1;
    assign bus.Rw_out         = r_rw_p1;
    assign bus.we_out         = r_we_p1;
    assign bus.jal_out        = r_jal_p1;
    assign bus.mem_to_reg_out = r_mem_to_reg_p1;
    assign bus.halt           = r_halt;
    assign bus.load_cnt       = r_load_cnt;
    assign bus.store_cnt      = r_store_cnt;

endmodule
